// File: rtl/lbp_result_sink.sv
// lbp_result_sink
//   Receiving end of the LBP engine result-write interface. Interior writes
//   land in an internal IMG_DIM x IMG_DIM frame and are counted. Border
//   writes are dropped and flagged. On finish the whole frame, with the
//   border forced to 0, streams out in raster order over valid/ready.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   lbp_valid/addr/data  write strobe, address {y, x}, LBP code
//   finish            single-cycle end-of-frame pulse
//   out_valid/ready   stream handshake
//   out_addr/data     raster address and pixel value of the current beat
//   out_last          high with the final pixel
//   busy              high while draining
//   done              one-cycle pulse after the last transfer
//   err_addr          sticky: a write hit a border address
//   err_count         accepted-write count at finish was not (IMG_DIM-2)^2
module lbp_result_sink #(
    parameter int IMG_DIM = 128,
    parameter int ADDR_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [7:0]        lbp_data,
    input  logic              finish,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err_addr,
    output logic              err_count
);
    localparam int                CW        = ADDR_W / 2;
    localparam int                NPIX      = IMG_DIM * IMG_DIM;
    localparam logic [14:0]       EXP_CNT   = 15'((IMG_DIM - 2) * (IMG_DIM - 2));
    localparam logic [CW-1:0]     EDGE      = CW'(IMG_DIM - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [7:0]        mem [NPIX];
    logic [14:0]       wcount, wcount_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_ok, wr_bad, xfer;

    function automatic logic is_border(input logic [ADDR_W-1:0] a);
        logic [CW-1:0] x, y;
        x = a[CW-1:0];
        y = a[ADDR_W-1:CW];
        return (x == '0) || (x == EDGE) || (y == '0) || (y == EDGE);
    endfunction

    // Writes are only honoured while collecting; late traffic is ignored.
    assign wr_ok  = (state == COLLECT) && lbp_valid && !is_border(lbp_addr);
    assign wr_bad = (state == COLLECT) && lbp_valid &&  is_border(lbp_addr);
    assign xfer   = out_valid && out_ready;

    // Count including this cycle's write so a write coincident with finish
    // takes part in the count check.
    assign wcount_nxt = (wr_ok && (wcount != '1)) ? wcount + 15'd1 : wcount;

    // Frame storage, intentionally not reset so contents survive frames.
    always_ff @(posedge clk) begin
        if (wr_ok && !reset)
            mem[lbp_addr] <= lbp_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_addr  = '0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        case (state)
            COLLECT: begin
                if (finish)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_addr  = rd_addr;
                out_data  = is_border(rd_addr) ? 8'h00 : mem[rd_addr];
                out_last  = (rd_addr == LAST_ADDR);
                if (xfer && out_last)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcount    <= '0;
            err_addr  <= 1'b0;
            err_count <= 1'b0;
            rd_addr   <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    wcount <= wcount_nxt;
                    if (wr_bad)
                        err_addr <= 1'b1;
                    if (finish) begin
                        err_count <= (wcount_nxt != EXP_CNT);
                        rd_addr   <= '0;
                    end
                end
                DRAIN: begin
                    if (xfer && !out_last)
                        rd_addr <= rd_addr + ADDR_W'(1);
                end
                DONE: begin
                    wcount    <= '0;
                    err_addr  <= 1'b0;
                    err_count <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
